// File: rtl/csi_pkg.sv
// Shared constants, header layout, FSM state and data-type mapping for the CSI-2 packet decoder.
package csi_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned DT_W   = 6;
  localparam int unsigned TYPE_W = 3;
  localparam int unsigned WC_W   = 16;
  localparam int unsigned REM_W  = 14;

  localparam logic [WORD_W-1:0] SYNC_WORD = 32'hB8B8B8B8;

  localparam logic [DT_W-1:0] DT_RAW8     = 6'h2A;
  localparam logic [DT_W-1:0] DT_RAW10    = 6'h2B;
  localparam logic [DT_W-1:0] DT_RAW12    = 6'h2C;
  localparam logic [DT_W-1:0] DT_YUV422_8 = 6'h1E;
  localparam logic [DT_W-1:0] DT_RGB565   = 6'h22;
  localparam logic [DT_W-1:0] DT_RGB888   = 6'h24;
  localparam logic [DT_W-1:0] DT_LONG_MIN = 6'h10;

  localparam logic [TYPE_W-1:0] PT_NONE     = 3'd0;
  localparam logic [TYPE_W-1:0] PT_RAW8     = 3'd1;
  localparam logic [TYPE_W-1:0] PT_RAW10    = 3'd2;
  localparam logic [TYPE_W-1:0] PT_RAW12    = 3'd3;
  localparam logic [TYPE_W-1:0] PT_YUV422_8 = 3'd4;
  localparam logic [TYPE_W-1:0] PT_RGB565   = 3'd5;
  localparam logic [TYPE_W-1:0] PT_RGB888   = 3'd6;
  localparam logic [TYPE_W-1:0] PT_OTHER    = 3'd7;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_e;

  // Packet header as it arrives on the four lanes: lane 0 carries DI.
  typedef struct packed {
    logic [7:0]      ecc;
    logic [WC_W-1:0] wc;
    logic [7:0]      di;
  } ph_t;

  function automatic logic [TYPE_W-1:0] dt_to_type(input logic [DT_W-1:0] dt);
    logic [TYPE_W-1:0] code;
    case (dt)
      DT_RAW8:     code = PT_RAW8;
      DT_RAW10:    code = PT_RAW10;
      DT_RAW12:    code = PT_RAW12;
      DT_YUV422_8: code = PT_YUV422_8;
      DT_RGB565:   code = PT_RGB565;
      DT_RGB888:   code = PT_RGB888;
      default:     code = PT_OTHER;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/csi_packet_decoder.sv
// CSI-2 packet decoder: hunts the 4-lane sync word, parses the packet header and
// forwards long-packet payload words one clock after they arrive.
module csi_packet_decoder
  import csi_pkg::WORD_W, csi_pkg::DT_W, csi_pkg::TYPE_W, csi_pkg::WC_W, csi_pkg::REM_W,
         csi_pkg::DT_LONG_MIN, csi_pkg::PT_NONE, csi_pkg::state_e, csi_pkg::ST_HUNT,
         csi_pkg::ST_HEADER, csi_pkg::ST_PAYLOAD, csi_pkg::ph_t, csi_pkg::dt_to_type;
#(
  parameter logic [31:0] SYNC_WORD = csi_pkg::SYNC_WORD
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              data_valid_i,
  input  logic [WORD_W-1:0] data_i,
  output logic              output_valid_o,
  output logic [WORD_W-1:0] data_o,
  output logic [WORD_W-1:0] packet_length_o,
  output logic [TYPE_W-1:0] packet_type_o
);

  localparam int unsigned WORDS_W = WC_W + 1;

  state_e              state_q, state_d;
  logic [REM_W-1:0]    rem_q, rem_d;
  logic                valid_q, valid_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic [WORD_W-1:0]   len_q, len_d;
  logic [TYPE_W-1:0]   type_q, type_d;

  ph_t                 hdr_c;
  logic [DT_W-1:0]     dt_c;
  logic [WORDS_W-1:0]  words_c;
  logic                unused_c;

  assign hdr_c    = ph_t'(data_i);
  assign dt_c     = hdr_c.di[DT_W-1:0];
  // Payload word count, ceil(WC/4); at most 16384 so one less fits the 14-bit counter.
  assign words_c  = (WORDS_W'(hdr_c.wc) + WORDS_W'(3)) >> 2;
  assign unused_c = ^{hdr_c.ecc, hdr_c.di[7:DT_W]};

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    valid_d = 1'b0;
    data_d  = data_q;
    len_d   = len_q;
    type_d  = type_q;

    case (state_q)
      ST_HUNT: begin
        if (data_valid_i && (data_i == SYNC_WORD)) begin
          state_d = ST_HEADER;
        end
      end

      ST_HEADER: begin
        state_d = ST_HUNT;
        if (data_valid_i && (dt_c >= DT_LONG_MIN)) begin
          len_d  = WORD_W'(hdr_c.wc);
          type_d = dt_to_type(dt_c);
          // rem_q counts words still to come after the current one.
          rem_d  = REM_W'(words_c - WORDS_W'(1));
          if (hdr_c.wc != WC_W'(0)) begin
            state_d = ST_PAYLOAD;
          end
        end
      end

      ST_PAYLOAD: begin
        if (!data_valid_i) begin
          state_d = ST_HUNT;
        end else begin
          valid_d = 1'b1;
          data_d  = data_i;
          if (rem_q == REM_W'(0)) begin
            state_d = ST_HUNT;
          end else begin
            rem_d = rem_q - REM_W'(1);
          end
        end
      end

      default: state_d = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_HUNT;
      rem_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      len_q   <= '0;
      type_q  <= PT_NONE;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      len_q   <= len_d;
      type_q  <= type_d;
    end
  end

  assign output_valid_o  = valid_q;
  assign data_o          = data_q;
  assign packet_length_o = len_q;
  assign packet_type_o   = type_q;

endmodule

// File: tb/tb_csi_packet_decoder.sv
// Directed self-checking bench for csi_packet_decoder with a packet-level expectation model.
module tb_csi_packet_decoder;

  localparam logic [31:0] SYNC = 32'hB8B8B8B8;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        data_valid_i;
  logic [31:0] data_i;
  logic        output_valid_o;
  logic [31:0] data_o;
  logic [31:0] packet_length_o;
  logic [2:0]  packet_type_o;

  csi_packet_decoder dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .data_valid_i   (data_valid_i),
    .data_i         (data_i),
    .output_valid_o (output_valid_o),
    .data_o         (data_o),
    .packet_length_o(packet_length_o),
    .packet_type_o  (packet_type_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          chk_en = 1'b0;
  logic        exp_valid = 1'b0;
  logic [31:0] exp_data = '0;
  logic [31:0] exp_len = '0;
  logic [2:0]  exp_type = '0;
  int          vcount = 0;
  logic [31:0] last_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] model_type(input logic [5:0] dt);
    case (dt)
      6'h2A:   return 3'd1;
      6'h2B:   return 3'd2;
      6'h2C:   return 3'd3;
      6'h1E:   return 3'd4;
      6'h22:   return 3'd5;
      6'h24:   return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

  // Per-cycle comparison against the model, half a clock after the active edge.
  always @(negedge clk_i) begin
    if (chk_en) begin
      check("output_valid", 32'(output_valid_o), 32'(exp_valid));
      check("packet_length", packet_length_o, exp_len);
      check("packet_type", 32'(packet_type_o), 32'(exp_type));
      if (exp_valid) check("data", data_o, exp_data);
      if (output_valid_o) begin
        vcount++;
        last_data = data_o;
      end
    end
  end

  // Present one input word; ev/ed describe the outputs expected after this edge.
  task automatic step(input logic v, input logic [31:0] d, input logic ev, input logic [31:0] ed);
    data_valid_i = v;
    data_i       = d;
    @(posedge clk_i);
    #1;
    exp_valid = ev;
    exp_data  = ed;
    chk_en    = 1'b1;
  endtask

  // Sync + header + up to `supplied` payload words (base + i*inc), optional drop and sync-in-payload.
  task automatic send_packet(input logic [31:0] hdr, input int supplied, input int drop_at,
                             input logic [31:0] base, input logic [31:0] inc, input int sync_at);
    int          wc;
    int          words;
    logic [31:0] w;
    wc    = int'({hdr[23:16], hdr[15:8]});
    words = (wc + 3) / 4;
    if (hdr[5:0] < 6'h10) words = 0;
    step(1'b1, SYNC, 1'b0, '0);
    step(1'b1, hdr, 1'b0, '0);
    if (hdr[5:0] >= 6'h10) begin
      exp_len  = 32'(wc);
      exp_type = model_type(hdr[5:0]);
    end
    for (int i = 0; i < supplied; i++) begin
      if (i == drop_at) begin
        step(1'b0, 32'h0BAD0BAD, 1'b0, '0);
        return;
      end
      w = (i == sync_at) ? SYNC : base + 32'(i) * inc;
      step(1'b1, w, (i < words), w);
    end
  endtask

  initial begin
    reset_n_i    = 1'b0;
    data_valid_i = 1'b0;
    data_i       = '0;
    #2;
    check("rst_valid", 32'(output_valid_o), 32'd0);
    check("rst_data", data_o, 32'd0);
    check("rst_len", packet_length_o, 32'd0);
    check("rst_type", 32'(packet_type_o), 32'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;

    // Idle words, including a sync pattern with valid low, must not start a packet.
    step(1'b0, '0, 1'b0, '0);
    step(1'b0, SYNC, 1'b0, '0);
    step(1'b0, 32'hAB09602B, 1'b0, '0);
    step(1'b0, '0, 1'b0, '0);
    check("idle_len", packet_length_o, 32'd0);
    check("idle_type", 32'(packet_type_o), 32'd0);

    // RAW10, WC=2400: 600 words forwarded, 8 trailing words ignored.
    step(1'b1, '0, 1'b0, '0);
    step(1'b1, '0, 1'b0, '0);
    vcount = 0;
    send_packet(32'hAB09602B, 608, -1, 32'd0, 32'd40000, -1);
    step(1'b0, '0, 1'b0, '0);
    check("raw10_count", 32'(vcount), 32'd600);
    check("raw10_last", last_data, 32'd23960000);
    check("raw10_len", packet_length_o, 32'd2400);
    check("raw10_type", 32'(packet_type_o), 32'd2);

    // Same header, valid dropped after 100 words.
    vcount = 0;
    send_packet(32'hAB09602B, 200, 100, 32'd0, 32'd40000, -1);
    step(1'b1, 32'h01020304, 1'b0, '0);
    check("drop_count", 32'(vcount), 32'd100);

    // RAW8 WC=64 after the abort.
    vcount = 0;
    send_packet(32'h5A00402A, 16, -1, 32'h10000000, 32'd1, -1);
    step(1'b0, '0, 1'b0, '0);
    check("raw8_count", 32'(vcount), 32'd16);
    check("raw8_len", packet_length_o, 32'd64);
    check("raw8_type", 32'(packet_type_o), 32'd1);

    // Short packet (frame start) leaves length/type alone.
    vcount = 0;
    send_packet(32'h00000000, 0, -1, '0, '0, -1);
    step(1'b1, 32'h12345678, 1'b0, '0);
    step(1'b1, 32'h9ABCDEF0, 1'b0, '0);
    check("short_count", 32'(vcount), 32'd0);
    check("short_len", packet_length_o, 32'd64);
    check("short_type", 32'(packet_type_o), 32'd1);

    // WC=5 rounds up to 2 words; the third supplied word is CRC and ignored.
    vcount = 0;
    send_packet(32'h3F00052B, 3, -1, 32'hA0A0A0A0, 32'h01010101, -1);
    step(1'b0, '0, 1'b0, '0);
    check("wc5_count", 32'(vcount), 32'd2);
    check("wc5_len", packet_length_o, 32'd5);
    check("wc5_type", 32'(packet_type_o), 32'd2);

    // Sync pattern inside the payload is plain data.
    vcount = 0;
    send_packet(32'h00001024, 4, -1, 32'h00C0FFEE, 32'd7, 1);
    step(1'b1, 32'h11111111, 1'b0, '0);
    check("syncpl_count", 32'(vcount), 32'd4);
    check("syncpl_len", packet_length_o, 32'd16);
    check("syncpl_type", 32'(packet_type_o), 32'd6);

    // Unlisted long data type still forwarded with code 7.
    vcount = 0;
    send_packet(32'h00000830, 2, -1, 32'h55AA0000, 32'd3, -1);
    step(1'b0, '0, 1'b0, '0);
    check("other_count", 32'(vcount), 32'd2);
    check("other_type", 32'(packet_type_o), 32'd7);

    // Reset in the middle of a payload.
    send_packet(32'hAB09602B, 5, -1, 32'h77000000, 32'd1, -1);
    chk_en    = 1'b0;
    reset_n_i = 1'b0;
    #1;
    check("midrst_valid", 32'(output_valid_o), 32'd0);
    check("midrst_data", data_o, 32'd0);
    check("midrst_len", packet_length_o, 32'd0);
    check("midrst_type", 32'(packet_type_o), 32'd0);
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    exp_valid = 1'b0;
    exp_len   = '0;
    exp_type  = '0;
    vcount    = 0;
    send_packet(32'h0000082C, 2, -1, 32'h33330000, 32'd9, -1);
    step(1'b0, '0, 1'b0, '0);
    check("post_count", 32'(vcount), 32'd2);
    check("post_len", packet_length_o, 32'd8);
    check("post_type", 32'(packet_type_o), 32'd3);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
